// File: rtl/exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : exe_muldiv
// Purpose  : Execute stage for the five-stage RISC-V pipeline. Single-cycle
//            RV32I/RV64I ALU, branch, jump, LUI/AUIPC and store-data path.
//            Fixed-latency M-extension multiplier and radix-2 restoring
//            divider under a small FSM that stalls the upstream pipeline.
// Ports    : clk_i/rst_i      clock, synchronous active-high reset
//            pc_i..rs2_i      decoded/forwarded instruction fields
//            flush_i          kills the current instruction (incl. M ops)
//            rd_*_o, mem_*_o  registered results towards memory stage
//            jump_addr_o/je_o registered branch/jump redirect
//            stall_o          combinational hold request to pipectrl
// Revision : 1.0 - initial release
// ============================================================================
module exe_muldiv #(
    parameter int              XLEN       = 32,
    parameter int              MUL_LAT    = 2,
    parameter logic [XLEN-1:0] RST_PC_VAL = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_we_i,
    input  logic [2:0]      opfunc3_i,
    input  logic [2:0]      optype_i,
    input  logic            shiftsel_i,
    input  logic            addsubsel_i,
    input  logic            jtypesel_i,
    input  logic            mem_re_i,
    input  logic            mem_we_i,
    input  logic            mdsel_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_re_o,
    output logic            mem_we_o,
    output logic [2:0]      opfunc3_o,
    output logic [XLEN-1:0] jump_addr_o,
    output logic            je_o,
    output logic            stall_o
);

    localparam int c_SHW  = $clog2(XLEN);
    localparam int c_CNTW = $clog2(XLEN);

    localparam logic [2:0] c_OT_R     = 3'd0;
    localparam logic [2:0] c_OT_I     = 3'd1;
    localparam logic [2:0] c_OT_B     = 3'd2;
    localparam logic [2:0] c_OT_S     = 3'd3;
    localparam logic [2:0] c_OT_LUI   = 3'd4;
    localparam logic [2:0] c_OT_AUIPC = 3'd5;
    localparam logic [2:0] c_OT_J     = 3'd6;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  w_op1, w_op2, w_sum, w_diff, w_alu, w_res, w_tgt;
    logic [XLEN-1:0]  w_pc_imm, w_mem_addr, w_jalr, w_link;
    logic [c_SHW-1:0] w_shamt;
    logic             w_lt, w_ltu, w_eq, w_br, w_taken, w_is_m;

    assign w_op1      = (optype_i == c_OT_LUI) ? '0 : rs1_i;
    assign w_op2      = (optype_i == c_OT_I || optype_i == c_OT_LUI) ? imm_i : rs2_i;
    assign w_shamt    = w_op2[c_SHW-1:0];
    assign w_sum      = w_op1 + w_op2;
    assign w_diff     = w_op1 - w_op2;
    assign w_lt       = $signed(w_op1) < $signed(w_op2);
    assign w_ltu      = w_op1 < w_op2;
    assign w_eq       = (w_op1 == w_op2);
    assign w_pc_imm   = pc_i + imm_i;
    assign w_mem_addr = rs1_i + imm_i;
    assign w_jalr     = {w_mem_addr[XLEN-1:1], 1'b0};
    assign w_link     = pc_i + XLEN'(4);
    assign w_is_m     = (optype_i == c_OT_R) && mdsel_i;

    always_comb begin
        w_alu = '0;
        case (opfunc3_i)
            // funct7 SUB bit is only meaningful for register-register ops
            3'b000:  w_alu = (optype_i == c_OT_R && addsubsel_i) ? w_diff : w_sum;
            3'b001:  w_alu = w_op1 << w_shamt;
            3'b010:  w_alu = {{(XLEN-1){1'b0}}, w_lt};
            3'b011:  w_alu = {{(XLEN-1){1'b0}}, w_ltu};
            3'b100:  w_alu = w_op1 ^ w_op2;
            3'b101:  w_alu = shiftsel_i ? $unsigned($signed(w_op1) >>> w_shamt)
                                        : (w_op1 >> w_shamt);
            3'b110:  w_alu = w_op1 | w_op2;
            default: w_alu = w_op1 & w_op2;
        endcase
    end

    always_comb begin
        w_br = 1'b0;
        case (opfunc3_i)
            3'b000:  w_br = w_eq;
            3'b001:  w_br = !w_eq;
            3'b100:  w_br = w_lt;
            3'b101:  w_br = !w_lt;
            3'b110:  w_br = w_ltu;
            3'b111:  w_br = !w_ltu;
            default: w_br = 1'b0;
        endcase
    end

    always_comb begin
        w_res   = w_alu;
        w_tgt   = w_pc_imm;
        w_taken = 1'b0;
        case (optype_i)
            c_OT_B:     w_taken = w_br;
            c_OT_S:     w_res   = rs2_i;
            c_OT_LUI:   w_res   = w_sum;
            c_OT_AUIPC: w_res   = w_pc_imm;
            c_OT_J: begin
                w_res   = w_link;
                w_taken = 1'b1;
                if (!jtypesel_i) w_tgt = w_jalr;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // M-extension datapath
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [c_CNTW-1:0] r_cnt;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_a, r_b, r_quo, r_rem, r_dvs;
    logic              r_qneg, r_rneg, r_div0;

    // Divide operands are captured as magnitudes; signs are re-applied at the end
    logic w_dsigned, w_na, w_nb;
    assign w_dsigned = !opfunc3_i[0];
    assign w_na      = w_dsigned & rs1_i[XLEN-1];
    assign w_nb      = w_dsigned & rs2_i[XLEN-1];

    // One restoring step: shift remainder:quotient left, trial-subtract divisor
    logic [XLEN:0]   w_rem_sh, w_trial;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nx, w_quo_nx, w_quo_fin, w_rem_fin;
    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_dvs};
    assign w_ge     = !w_trial[XLEN];
    assign w_rem_nx = w_ge ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

    // The DIV state runs XLEN-1 steps; the final step is taken in DONE.
    // Signed overflow needs no special case: |MIN|/1 = MIN with equal signs
    // and a zero remainder, which is exactly the required result.
    assign w_quo_fin = r_div0 ? '1  : (r_qneg ? -w_quo_nx : w_quo_nx);
    assign w_rem_fin = r_div0 ? r_a : (r_rneg ? -w_rem_nx : w_rem_nx);

    // Multiply: operands extended to 2*XLEN so one unsigned product covers all
    logic              w_sgn_a, w_sgn_b;
    logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
    logic [XLEN-1:0]   w_md_res;
    assign w_sgn_a = (r_f3 == 3'b001) || (r_f3 == 3'b010);
    assign w_sgn_b = (r_f3 == 3'b001);
    assign w_ma    = {{XLEN{w_sgn_a & r_a[XLEN-1]}}, r_a};
    assign w_mb    = {{XLEN{w_sgn_b & r_b[XLEN-1]}}, r_b};
    assign w_prod  = w_ma * w_mb;

    always_comb begin
        w_md_res = '0;
        case (r_f3)
            3'b000:         w_md_res = w_prod[XLEN-1:0];
            3'b100, 3'b101: w_md_res = w_quo_fin;
            3'b110, 3'b111: w_md_res = w_rem_fin;
            default:        w_md_res = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    assign stall_o = !rst_i && !flush_i &&
                     ((r_state == c_IDLE && w_is_m) || r_state == c_MUL || r_state == c_DIV);

    // ------------------------------------------------------------------
    // FSM and output registers; every cycle defaults to a bubble
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_f3        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_div0      <= 1'b0;
            rd_addr_o   <= '0;
            rd_data_o   <= '0;
            rd_we_o     <= 1'b0;
            mem_addr_o  <= '0;
            mem_re_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            opfunc3_o   <= '0;
            jump_addr_o <= RST_PC_VAL;
            je_o        <= 1'b0;
        end else begin
            rd_addr_o  <= '0;
            rd_we_o    <= 1'b0;
            mem_re_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            je_o       <= 1'b0;
            mem_addr_o <= w_mem_addr;
            opfunc3_o  <= opfunc3_i;
            if (flush_i) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_is_m) begin
                            r_f3   <= opfunc3_i;
                            r_a    <= rs1_i;
                            r_b    <= rs2_i;
                            r_quo  <= w_na ? -rs1_i : rs1_i;
                            r_dvs  <= w_nb ? -rs2_i : rs2_i;
                            r_rem  <= '0;
                            r_qneg <= w_na ^ w_nb;
                            r_rneg <= w_na;
                            r_div0 <= (rs2_i == '0);
                            if (opfunc3_i[2]) begin
                                r_cnt   <= c_CNTW'(XLEN-1);
                                r_state <= c_DIV;
                            end else begin
                                r_cnt   <= c_CNTW'(MUL_LAT-1);
                                // The capture cycle itself is the only busy cycle
                                r_state <= (MUL_LAT == 1) ? c_DONE : c_MUL;
                            end
                        end else begin
                            rd_addr_o   <= rd_addr_i;
                            rd_data_o   <= w_res;
                            rd_we_o     <= rd_we_i;
                            mem_re_o    <= mem_re_i;
                            mem_we_o    <= mem_we_i;
                            jump_addr_o <= w_tgt;
                            je_o        <= w_taken;
                        end
                    end
                    c_MUL, c_DIV: begin
                        if (r_state == c_DIV) begin
                            r_rem <= w_rem_nx;
                            r_quo <= w_quo_nx;
                        end
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == c_CNTW'(1)) r_state <= c_DONE;
                    end
                    default: begin
                        rd_addr_o <= rd_addr_i;
                        rd_data_o <= w_md_res;
                        rd_we_o   <= rd_we_i;
                        r_state   <= c_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_muldiv
// Purpose  : Self-checking bench for exe_muldiv (XLEN=32, MUL_LAT=2).
//            Table of single-cycle vectors, directed M-op corner sequences,
//            flush sequences and random M ops against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_muldiv;

    localparam int          XLEN    = 32;
    localparam int          MUL_LAT = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0080;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i, imm_i, rs1_i, rs2_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic [2:0]  opfunc3_i, optype_i;
    logic        shiftsel_i, addsubsel_i, jtypesel_i;
    logic        mem_re_i, mem_we_i, mdsel_i, flush_i;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o, mem_addr_o, jump_addr_o;
    logic        rd_we_o, mem_re_o, mem_we_o, je_o, stall_o;
    logic [2:0]  opfunc3_o;

    always #5 clk_i = ~clk_i;

    exe_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .RST_PC_VAL(RST_PC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .imm_i(imm_i),
        .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .opfunc3_i(opfunc3_i),
        .optype_i(optype_i), .shiftsel_i(shiftsel_i), .addsubsel_i(addsubsel_i),
        .jtypesel_i(jtypesel_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
        .mdsel_i(mdsel_i), .flush_i(flush_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_we_o(rd_we_o),
        .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
        .opfunc3_o(opfunc3_o), .jump_addr_o(jump_addr_o), .je_o(je_o),
        .stall_o(stall_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  ot;
        logic [2:0]  f3;
        logic        sub;
        logic        sra;
        logic        jsel;
        logic [31:0] pc, imm, a, b;
        logic        chk_data;
        logic [31:0] data;
        logic        je;
        logic        chk_jump;
        logic [31:0] jump;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic [2:0] ot, input logic [2:0] f3,
                                 input logic sub, input logic sra, input logic jsel,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic chk_data, input logic [31:0] data,
                                 input logic je, input logic chk_jump,
                                 input logic [31:0] jump);
        vec_t v;
        v.ot = ot; v.f3 = f3; v.sub = sub; v.sra = sra; v.jsel = jsel;
        v.pc = pc; v.imm = imm; v.a = a; v.b = b;
        v.chk_data = chk_data; v.data = data; v.je = je;
        v.chk_jump = chk_jump; v.jump = jump;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] ot, input logic [2:0] f3, input logic md,
                          input logic [31:0] a, input logic [31:0] b);
        optype_i = ot; opfunc3_i = f3; mdsel_i = md; rs1_i = a; rs2_i = b;
        shiftsel_i = 1'b0; addsubsel_i = 1'b0; jtypesel_i = 1'b0;
        mem_re_i = 1'b0; mem_we_i = 1'b0; pc_i = 32'h40; imm_i = 32'h0;
    endtask

    // Reference for M ops, straight from the arithmetic definitions
    function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] up;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin sp = sa * sb; return sp[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'({32'h0, a} * 0 + {32'h0, b}); return sp[63:32]; end
            3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sp = sa % sb; return sp[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one M op and follow it to completion, counting stall cycles
    task automatic run_md(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
        int stalls = 0;
        int bad_bubble = 0;
        bit done = 0;
        @(negedge clk_i);
        set_op(3'd0, f3, 1'b1, a, b);
        rd_addr_i = 5'd9; rd_we_i = 1'b1; flush_i = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (stall_o) begin
                stalls++;
                @(posedge clk_i); #1;
                if (rd_we_o !== 1'b0 || je_o !== 1'b0 || rd_addr_o !== 5'd0 ||
                    mem_we_o !== 1'b0 || mem_re_o !== 1'b0) bad_bubble++;
                @(negedge clk_i);
            end else begin
                @(posedge clk_i); #1;
                done = 1;
            end
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout: stall still high after %0d cycles, expected %0d", name, stalls, exp_stall);
        end else begin
            check({name, " result"}, {32'h0, rd_data_o}, {32'h0, exp});
            check({name, " rd_we"}, {63'h0, rd_we_o}, 64'h1);
            check({name, " rd_addr"}, {59'h0, rd_addr_o}, 64'd9);
            check({name, " stall cycles"}, 64'(stalls), 64'(exp_stall));
            check({name, " bubbles"}, 64'(bad_bubble), 64'h0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Table of single-cycle operations
        vecs.push_back(mkv(0,0,0,0,0, 0,0, 5,7,                  1,32'd12,       0,0,0));
        vecs.push_back(mkv(0,0,1,0,0, 0,0, 5,7,                  1,32'hFFFFFFFE, 0,0,0));
        vecs.push_back(mkv(0,1,0,0,0, 0,0, 1,33,                 1,32'd2,        0,0,0));
        vecs.push_back(mkv(0,2,0,0,0, 0,0, 32'hFFFFFFFF,1,       1,32'd1,        0,0,0));
        vecs.push_back(mkv(0,3,0,0,0, 0,0, 32'hFFFFFFFF,1,       1,32'd0,        0,0,0));
        vecs.push_back(mkv(0,4,0,0,0, 0,0, 32'hF0F0,32'h0FF0,    1,32'hFF00,     0,0,0));
        vecs.push_back(mkv(0,5,0,1,0, 0,0, 32'h80000000,4,       1,32'hF8000000, 0,0,0));
        vecs.push_back(mkv(0,5,0,0,0, 0,0, 32'h80000000,4,       1,32'h08000000, 0,0,0));
        vecs.push_back(mkv(0,6,0,0,0, 0,0, 32'hF000,32'h00F0,    1,32'hF0F0,     0,0,0));
        vecs.push_back(mkv(0,7,0,0,0, 0,0, 32'hFF00,32'h0FF0,    1,32'h0F00,     0,0,0));
        vecs.push_back(mkv(1,0,0,0,0, 0,32'hFFFFFFFD, 10,99,     1,32'd7,        0,0,0));
        vecs.push_back(mkv(1,5,0,1,0, 0,2, 32'hFFFFFFF0,99,      1,32'hFFFFFFFC, 0,0,0));
        vecs.push_back(mkv(4,0,0,0,0, 0,32'h12345000, 32'hDEADBEEF,3, 1,32'h12345000, 0,0,0));
        vecs.push_back(mkv(5,0,0,0,0, 32'h1000,32'h2000, 7,3,    1,32'h3000,     0,1,32'h3000));
        vecs.push_back(mkv(6,0,0,0,1, 32'h200,32'h40, 32'h301,0, 1,32'h204,      1,1,32'h240));
        vecs.push_back(mkv(6,0,0,0,0, 32'h200,32'h10, 32'h301,0, 1,32'h204,      1,1,32'h310));
        vecs.push_back(mkv(2,4,0,0,0, 32'h100,32'h20, 32'hFFFFFFFF,1, 0,0,       1,1,32'h120));
        vecs.push_back(mkv(2,6,0,0,0, 32'h100,32'h20, 32'hFFFFFFFF,1, 0,0,       0,1,32'h120));
        vecs.push_back(mkv(2,0,0,0,0, 32'h100,32'h8, 5,5,        0,0,            1,1,32'h108));
        vecs.push_back(mkv(2,1,0,0,0, 32'h100,32'h8, 5,5,        0,0,            0,0,0));
        vecs.push_back(mkv(2,5,0,0,0, 32'h100,32'h8, 32'hFFFFFFFF,1, 0,0,        0,0,0));
        vecs.push_back(mkv(2,7,0,0,0, 32'h100,32'h8, 32'hFFFFFFFF,1, 0,0,        1,0,0));
        vecs.push_back(mkv(3,2,0,0,0, 0,8, 32'h1000,32'hCAFEF00D, 1,32'hCAFEF00D, 0,0,0));

        // Reset with an M op pending: stall must stay low, outputs at reset values
        rst_i = 1'b1; flush_i = 1'b0; rd_addr_i = 5'd1; rd_we_i = 1'b1;
        set_op(3'd0, 3'd4, 1'b1, 32'd7, 32'd3);
        repeat (3) @(posedge clk_i);
        #1;
        check("reset stall", {63'h0, stall_o}, 64'h0);
        check("reset rd_we", {63'h0, rd_we_o}, 64'h0);
        check("reset rd_data", {32'h0, rd_data_o}, 64'h0);
        check("reset jump_addr", {32'h0, jump_addr_o}, {32'h0, RST_PC});
        check("reset je", {63'h0, je_o}, 64'h0);
        @(negedge clk_i);
        set_op(3'd0, 3'd0, 1'b0, 32'd0, 32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic exp_we;
            v = vecs[i];
            exp_we = (v.ot != 3'd2) && (v.ot != 3'd3);
            @(negedge clk_i);
            set_op(v.ot, v.f3, 1'b0, v.a, v.b);
            addsubsel_i = v.sub; shiftsel_i = v.sra; jtypesel_i = v.jsel;
            pc_i = v.pc; imm_i = v.imm;
            mem_we_i = (v.ot == 3'd3);
            rd_we_i = exp_we; rd_addr_i = 5'(i + 1);
            #1;
            check($sformatf("vec%0d stall", i), {63'h0, stall_o}, 64'h0);
            @(posedge clk_i); #1;
            if (v.chk_data) check($sformatf("vec%0d rd_data", i), {32'h0, rd_data_o}, {32'h0, v.data});
            check($sformatf("vec%0d je", i), {63'h0, je_o}, {63'h0, v.je});
            if (v.chk_jump) check($sformatf("vec%0d jump_addr", i), {32'h0, jump_addr_o}, {32'h0, v.jump});
            check($sformatf("vec%0d rd_we", i), {63'h0, rd_we_o}, {63'h0, exp_we});
            check($sformatf("vec%0d rd_addr", i), {59'h0, rd_addr_o}, 64'(i + 1));
            if (v.ot == 3'd3) begin
                check($sformatf("vec%0d mem_addr", i), {32'h0, mem_addr_o}, {32'h0, v.a + v.imm});
                check($sformatf("vec%0d mem_we", i), {63'h0, mem_we_o}, 64'h1);
            end
        end

        // Directed M-op corners
        run_md("MULH min*min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        run_md("DIV 7/0",      3'd4, 32'd7, 32'd0, 32'hFFFFFFFF, XLEN);
        run_md("REM 7/0",      3'd6, 32'd7, 32'd0, 32'd7, XLEN);
        run_md("DIV ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, XLEN);
        run_md("REM ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, XLEN);
        run_md("DIVU 100/7",   3'd5, 32'd100, 32'd7, 32'd14, XLEN);
        run_md("REMU 100/7",   3'd7, 32'd100, 32'd7, 32'd2, XLEN);
        run_md("DIV -7/2",     3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, XLEN);
        run_md("REM -7/2",     3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, XLEN);
        run_md("MUL -3*5",     3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, MUL_LAT);

        // Flush in the middle of a divide
        @(negedge clk_i);
        set_op(3'd0, 3'd5, 1'b1, 32'd100, 32'd7);
        rd_addr_i = 5'd4; rd_we_i = 1'b1;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i); #1;
        check("div busy before flush", {63'h0, stall_o}, 64'h1);
        flush_i = 1'b1; #1;
        check("flush stall drop", {63'h0, stall_o}, 64'h0);
        @(posedge clk_i); #1;
        check("flush bubble rd_we", {63'h0, rd_we_o}, 64'h0);
        @(negedge clk_i);
        flush_i = 1'b0;
        set_op(3'd0, 3'd0, 1'b0, 32'd5, 32'd7);
        rd_addr_i = 5'd6; #1;
        check("post-flush stall", {63'h0, stall_o}, 64'h0);
        @(posedge clk_i); #1;
        check("post-flush ADD", {32'h0, rd_data_o}, 64'd12);
        check("post-flush rd_we", {63'h0, rd_we_o}, 64'h1);

        // Flush in IDLE with an M op present must not start the FSM
        @(negedge clk_i);
        set_op(3'd0, 3'd0, 1'b1, 32'd3, 32'd3);
        flush_i = 1'b1; #1;
        check("idle flush stall", {63'h0, stall_o}, 64'h0);
        @(posedge clk_i); #1;
        check("idle flush bubble", {63'h0, rd_we_o}, 64'h0);
        @(negedge clk_i);
        flush_i = 1'b0;
        set_op(3'd0, 3'd0, 1'b0, 32'd1, 32'd2);
        rd_addr_i = 5'd3; #1;
        check("after idle flush stall", {63'h0, stall_o}, 64'h0);
        @(posedge clk_i); #1;
        check("after idle flush ADD", {32'h0, rd_data_o}, 64'd3);

        // Random back-to-back M ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_md($sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b), f3, a, b,
                   md_ref(f3, a, b), f3[2] ? XLEN : MUL_LAT);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
- Parametrised execute stage for the five-stage RISC-V pipeline. Replaces the single-cycle ALU/branch stage.
- Performs RV32I/RV64I ALU, branch, jump, AUIPC, LUI and store-data operations in one cycle.
- Adds the RV M-extension: multiply over a fixed, parameter-set number of cycles, and iterative divide/remainder.
- Sits between decode/forwarding and memory. Drives stall_o to pipectrl while a multi-cycle operation is in flight.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- MUL_LAT, 2, multiply busy cycles; 1..4.
- RST_PC_VAL, 0, reset value of jump_addr_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- pc_i  in  XLEN  instruction PC.
- imm_i  in  XLEN  decoded immediate.
- rd_addr_i  in  5  destination register.
- rd_we_i  in  1  register write enable.
- opfunc3_i  in  3  funct3.
- optype_i  in  3  0 R, 1 I, 2 B, 3 S, 4 LUI, 5 AUIPC, 6 J.
- shiftsel_i  in  1  SRA/SRAI select.
- addsubsel_i  in  1  SUB select.
- jtypesel_i  in  1  1 JAL, 0 JALR.
- mem_re_i  in  1  load.
- mem_we_i  in  1  store.
- mdsel_i  in  1  R-type is an M-extension op.
- flush_i  in  1  kill the current instruction.
- rs1_i  in  XLEN  forwarded rs1.
- rs2_i  in  XLEN  forwarded rs2.
- rd_addr_o  out  5  to memory/forwarding.
- rd_data_o  out  XLEN  result, or store data.
- rd_we_o  out  1
- mem_addr_o  out  XLEN  rs1 + imm.
- mem_re_o  out  1
- mem_we_o  out  1
- opfunc3_o  out  3
- jump_addr_o  out  XLEN  to pipectrl.
- je_o  out  1  jump/branch taken.
- stall_o  out  1  to pipectrl; hold decode/forwarding inputs.

Behaviour:
- All outputs except stall_o are registered. On rst_i they reset to 0; jump_addr_o resets to RST_PC_VAL. FSM resets to IDLE.
- Non-M ops: single-cycle latency, result at the next edge.
  - op1 = 0 for LUI, otherwise rs1.
  - op2 = imm for I/LUI, otherwise rs2.
  - Shift amount is op2[log2(XLEN)-1:0].
  - Branch target = pc + imm. JAL target = pc + imm. JALR target = (rs1 + imm) with bit 0 cleared.
  - Link value = pc + 4. S-type rd_data_o = rs2.
  - Arithmetic wraps modulo 2^XLEN.
- M op: optype_i = 0 and mdsel_i = 1.
  - funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE, M op present: capture operands and funct3. Go to MUL (counter = MUL_LAT-1) or DIV (counter = XLEN-1). stall_o = 1.
  - MUL/DIV: stall_o = 1. One radix-2 restoring step per DIV cycle. Counter decrements; at 0 go to DONE.
  - DONE: stall_o = 0. The result registers onto the outputs together with the held rd_addr_i/rd_we_i. Return to IDLE.
  - Latency: MUL = MUL_LAT+1 cycles in stage; DIV/REM = XLEN+1 cycles. Latency is fixed and data-independent.
- Stall cycles register a bubble: rd_we_o = 0, mem_re_o = 0, mem_we_o = 0, je_o = 0, rd_addr_o = 0.
- Upstream holds all inputs stable while stall_o = 1. Input changes during stall are ignored; captured operands are used.
- Divide corner cases (RISC-V spec), applied in DONE:
  - Divisor 0: quotient all ones; remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend; remainder = 0.
  - Signed results: operate on magnitudes. Negate quotient if signs differ; remainder takes the dividend's sign.
- MULH variants return the upper XLEN bits of the 2*XLEN product with per-operand sign extension.
- flush_i:
  - Top priority after rst_i.
  - In any state: FSM goes to IDLE, stall_o drops in that same cycle (combinational), and a bubble is registered at that edge.
  - Flush in IDLE with an M op present does not start the FSM.
- A back-to-back M op after DONE starts in the following IDLE cycle.
- stall_o is combinational from FSM state and inputs; it is never asserted in reset.

Test Plan:
- Reset, then ADD rs1=5, rs2=7 -> next edge rd_data_o=12, rd_we_o=1, stall_o never high.
- BLT rs1=-1, rs2=1, pc=0x100, imm=0x20 -> je_o=1, jump_addr_o=0x120. BLTU with the same operands -> je_o=0.
- MULH rs1=0x80000000, rs2=0x80000000 (XLEN=32, MUL_LAT=2) -> stall_o high 2 cycles, then rd_data_o=0x40000000; bubbles during the stall.
- DIV 7 / 0 -> rd_data_o=0xFFFFFFFF after 33 cycles. REM 7 / 0 -> 7. DIV 0x80000000 / -1 -> 0x80000000. REM of the same operands -> 0.
- DIVU 100/7 -> 14, REMU -> 2. DIV -7/2 -> -3, REM -> -1. Each result follows exactly 32 stall cycles.
- flush_i asserted at DIV cycle 10 -> stall_o low the same cycle, rd_we_o=0 next edge. A following ADD completes normally.
